// File: rtl/cgra_cfg_pkg.sv
// Shared types for the CGRA config-stream loader.
//   cfg_state_e : loader session state
//   cfg_beat_t  : one host beat (address, data, last-of-session flag)
//   CFG_NOP_ADDR: reserved address, beats carrying it are dropped
package cgra_cfg_pkg;

    localparam int CFG_ADDR_W = 32;
    localparam int CFG_DATA_W = 32;

    localparam logic [CFG_ADDR_W-1:0] CFG_NOP_ADDR = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } cfg_state_e;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
        logic                  last;
    } cfg_beat_t;

endpackage

// File: rtl/cfg_fifo.sv
// Synchronous FIFO of cfg_beat_t.
//   clk_in, reset_in_n : clock, async active-low reset (flushes pointers)
//   push, din          : write a beat (ignored when full)
//   pop, dout          : dout is the head beat; pop advances (ignored when empty)
//   full, empty        : registered-pointer status, no push/pop bypass
module cfg_fifo
    import cgra_cfg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_in,
    input  logic      reset_in_n,
    input  logic      push,
    input  cfg_beat_t din,
    input  logic      pop,
    output cfg_beat_t dout,
    output logic      full,
    output logic      empty
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] PTR_ONE = 1;

    // One extra pointer bit: equal indices with differing MSBs means full.
    logic [IW:0] wr_ptr_q, wr_ptr_d;
    logic [IW:0] rd_ptr_q, rd_ptr_d;
    cfg_beat_t   mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                   (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign dout  = mem_q[rd_ptr_q[IW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_in or negedge reset_in_n) begin
        if (!reset_in_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (push && !full) mem_q[wr_ptr_q[IW-1:0]] <= din;
    end

endmodule

// File: rtl/cgra_config_loader.sv
// Config-stream front end for the CGRA config_addr_in/config_data_in bus.
//   clk_in, reset_in_n      : clock, async active-low reset
//   start_in                : pulse, starts a session from IDLE or DONE
//   cfg_valid_in/ready_out  : host beat handshake; cfg_addr/data/last_in carry the beat
//   config_addr/data_out    : replayed writes, addr 0 when idle
//   config_done_out         : session finished and bus settled
//   busy_out                : LOAD or SETTLE
//   err_out                 : an addr-0 beat was seen this session
//   write_count_out         : writes issued this session, saturating
module cgra_config_loader
    import cgra_cfg_pkg::*;
#(
    parameter int ADDR_W        = CFG_ADDR_W,
    parameter int DATA_W        = CFG_DATA_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk_in,
    input  logic              reset_in_n,
    input  logic              start_in,
    input  logic              cfg_valid_in,
    output logic              cfg_ready_out,
    input  logic [ADDR_W-1:0] cfg_addr_in,
    input  logic [DATA_W-1:0] cfg_data_in,
    input  logic              cfg_last_in,
    output logic [ADDR_W-1:0] config_addr_out,
    output logic [DATA_W-1:0] config_data_out,
    output logic              config_done_out,
    output logic              busy_out,
    output logic              err_out,
    output logic [15:0]       write_count_out
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    cfg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic              last_seen_q, last_seen_d;
    logic [SW-1:0]     settle_q, settle_d;

    logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
    cfg_beat_t beat_in, beat_head;

    assign beat_in = '{addr: cfg_addr_in, data: cfg_data_in, last: cfg_last_in};

    assign cfg_ready_out = (state_q == LOAD) && !fifo_full && !last_seen_q;
    assign fifo_push     = cfg_valid_in && cfg_ready_out;

    cfg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in     (clk_in),
        .reset_in_n (reset_in_n),
        .push       (fifo_push),
        .din        (beat_in),
        .pop        (fifo_pop),
        .dout       (beat_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = '0;          // bus returns to idle unless a write is issued
        data_d      = data_q;      // data holds through idle cycles
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        last_seen_d = last_seen_q;
        settle_d    = settle_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_in) begin
                    state_d     = LOAD;
                    wcnt_d      = '0;
                    err_d       = 1'b0;
                    last_seen_d = 1'b0;
                end
            end
            LOAD: begin
                if (fifo_push && cfg_last_in) last_seen_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (beat_head.addr != CFG_NOP_ADDR) begin
                        addr_d = beat_head.addr;
                        data_d = beat_head.data;
                        if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (beat_head.last) begin
                        state_d  = SETTLE;
                        settle_d = '0;
                    end
                end
            end
            SETTLE: begin
                // First SETTLE cycle still shows the final write; the next
                // SETTLE_CYCLES cycles are the idle ones that are counted.
                if (settle_q == SW'(SETTLE_CYCLES)) begin
                    state_d = DONE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
            settle_q    <= settle_d;
        end
    end

    assign config_addr_out = addr_q;
    assign config_data_out = data_q;
    assign config_done_out = (state_q == DONE);
    assign busy_out        = (state_q == LOAD) || (state_q == SETTLE);
    assign err_out         = err_q;
    assign write_count_out = wcnt_q;

endmodule
